// File: rtl/rv32_decode_alu_branch_pkg.sv
// Shared encodings for the RV32IM decode/execute slice: opcodes, ALU operation
// codes, funct3 encodings and the immediate extractor.
package rv32_decode_alu_branch_pkg;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13
  } alu_op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  function automatic logic [31:0] imm_for(input logic [31:0] instr);
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_MISC_MEM:
        imm_for = {{20{instr[31]}}, instr[31:20]};
      OPC_STORE:
        imm_for = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPC_BRANCH:
        imm_for = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm_for = {instr[31:12], 12'b0};
      OPC_JAL:
        imm_for = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default:
        imm_for = '0;
    endcase
  endfunction

endpackage

// File: rtl/rv32_decode_alu_branch_alu.sv
// Integer ALU for RV32IM (no divide); all arithmetic wraps mod 2^32.
module rv32_decode_alu_branch_alu
  import rv32_decode_alu_branch_pkg::*;
(
  input  logic [4:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic        [4:0]  shamt;
  logic signed [63:0] a_x;
  logic signed [63:0] b_x;
  logic signed [63:0] prod;

  assign shamt = b[4:0];

  // One shared multiplier; operand extension picks the MULH signedness.
  // MUL takes the low half, which is the same for any extension.
  assign a_x  = (alu_op == ALU_MULHU) ? $signed({32'b0, a}) : $signed({{32{a[31]}}, a});
  assign b_x  = (alu_op == ALU_MULH)  ? $signed({{32{b[31]}}, b}) : $signed({32'b0, b});
  assign prod = a_x * b_x;

  always_comb begin
    case (alu_op)
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_SLL:    y = a << shamt;
      ALU_SLT:    y = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:   y = {31'b0, a < b};
      ALU_XOR:    y = a ^ b;
      ALU_SRL:    y = a >> shamt;
      ALU_SRA:    y = $signed(a) >>> shamt;
      ALU_OR:     y = a | b;
      ALU_AND:    y = a & b;
      ALU_MUL:    y = prod[31:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  y = prod[63:32];
      default:    y = '0;
    endcase
  end

endmodule

// File: rtl/rv32_decode_alu_branch_branch_unit.sv
// Conditional branch resolver comparing the two forwarded source operands.
module rv32_decode_alu_branch_branch_unit
  import rv32_decode_alu_branch_pkg::*;
(
  input  logic        is_branch,
  input  logic [2:0]  b_type,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        take_branch
);

  logic cond;

  always_comb begin
    case (b_type)
      F3_BEQ:  cond = (a == b);
      F3_BNE:  cond = (a != b);
      F3_BLT:  cond = ($signed(a) <  $signed(b));
      F3_BGE:  cond = ($signed(a) >= $signed(b));
      F3_BLTU: cond = (a <  b);
      F3_BGEU: cond = (a >= b);
      default: cond = 1'b0;
    endcase
    take_branch = is_branch & cond;
  end

endmodule

// File: rtl/rv32_decode_alu_branch_decoder.sv
// RV32IM instruction decoder: control flags, funct3 copies, ALU op and immediate.
module rv32_decode_alu_branch_decoder
  import rv32_decode_alu_branch_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output logic [4:0]  alu_op,
  output logic        reg_write,
  output logic        alu_src,
  output logic        is_branch,
  output logic        jal_jump,
  output logic        jalr_jump,
  output logic        is_load,
  output logic        is_store,
  output logic        is_lui,
  output logic        is_auipc,
  output logic        is_div,
  output logic        cpu_halt,
  output logic        illegal,
  output logic [2:0]  b_type,
  output logic [2:0]  load_type,
  output logic [2:0]  store_type,
  output logic [2:0]  div_op,
  output logic [2:0]  csr_func
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  alu_op_e    op;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign alu_op = op;

  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  function automatic alu_op_e mul_op(input logic [1:0] f3);
    case (f3)
      2'b00:   mul_op = ALU_MUL;
      2'b01:   mul_op = ALU_MULH;
      2'b10:   mul_op = ALU_MULHSU;
      default: mul_op = ALU_MULHU;
    endcase
  endfunction

  always_comb begin
    op         = ALU_ADD;
    imm        = imm_for(instr);
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    is_branch  = 1'b0;
    jal_jump   = 1'b0;
    jalr_jump  = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_lui     = 1'b0;
    is_auipc   = 1'b0;
    is_div     = 1'b0;
    cpu_halt   = 1'b0;
    illegal    = 1'b0;
    b_type     = 3'b000;
    load_type  = 3'b000;
    store_type = 3'b000;
    div_op     = 3'b000;
    csr_func   = 3'b000;
    case (opcode)
      OPC_OP: begin
        reg_write = 1'b1;
        case (funct7)
          F7_BASE: op = base_op(funct3);
          F7_ALT: begin
            if (funct3 == 3'b000)      op = ALU_SUB;
            else if (funct3 == 3'b101) op = ALU_SRA;
            else                       illegal = 1'b1;
          end
          F7_MULDIV: begin
            // Divides run in an external unit; only the request is flagged here.
            if (funct3[2]) begin
              is_div = 1'b1;
              div_op = funct3;
            end else begin
              op = mul_op(funct3[1:0]);
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        op        = base_op(funct3);
        if (funct3 == 3'b001 && funct7 != F7_BASE) illegal = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT)        op = ALU_SRA;
          else if (funct7 != F7_BASE)  illegal = 1'b1;
        end
      end
      OPC_LOAD: begin
        if (funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}) begin
          is_load   = 1'b1;
          load_type = funct3;
          reg_write = 1'b1;
          alu_src   = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3 inside {F3_SB, F3_SH, F3_SW}) begin
          is_store   = 1'b1;
          store_type = funct3;
          alu_src    = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU}) begin
          is_branch = 1'b1;
          b_type    = funct3;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_JAL: begin
        jal_jump  = 1'b1;
        reg_write = 1'b1;
      end
      OPC_JALR: begin
        jalr_jump = 1'b1;
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      OPC_LUI: begin
        is_lui    = 1'b1;
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      OPC_AUIPC: begin
        is_auipc  = 1'b1;
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      OPC_SYSTEM: begin
        if (funct3 == 3'b000) begin
          cpu_halt = 1'b1;
        end else begin
          csr_func  = funct3;
          reg_write = 1'b1;
        end
      end
      OPC_MISC_MEM: ;
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      op         = ALU_ADD;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      is_branch  = 1'b0;
      is_load    = 1'b0;
      is_store   = 1'b0;
      is_div     = 1'b0;
      b_type     = 3'b000;
      load_type  = 3'b000;
      store_type = 3'b000;
      div_op     = 3'b000;
    end
  end

endmodule

// File: rtl/rv32_decode_alu_branch.sv
// Decode + execute slice: decoder, ALU and branch unit, result mux, target adder
// and the registered fetch redirect.
module rv32_decode_alu_branch (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic [4:0]  alu_op,
  output logic        reg_write,
  output logic        alu_src,
  output logic        is_branch,
  output logic        jal_jump,
  output logic        jalr_jump,
  output logic        is_load,
  output logic        is_store,
  output logic        is_lui,
  output logic        is_auipc,
  output logic        is_div,
  output logic        cpu_halt,
  output logic        illegal,
  output logic [2:0]  b_type,
  output logic [2:0]  load_type,
  output logic [2:0]  store_type,
  output logic [2:0]  div_op,
  output logic [2:0]  csr_func,
  output logic [31:0] result,
  output logic        take_branch,
  output logic [31:0] pc_target,
  output logic        flush
);

  logic [31:0] op_b;
  logic [31:0] alu_y;

  assign rd  = instr[11:7];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];

  rv32_decode_alu_branch_decoder u_decoder (
    .instr      (instr),
    .imm        (imm),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .alu_src    (alu_src),
    .is_branch  (is_branch),
    .jal_jump   (jal_jump),
    .jalr_jump  (jalr_jump),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_lui     (is_lui),
    .is_auipc   (is_auipc),
    .is_div     (is_div),
    .cpu_halt   (cpu_halt),
    .illegal    (illegal),
    .b_type     (b_type),
    .load_type  (load_type),
    .store_type (store_type),
    .div_op     (div_op),
    .csr_func   (csr_func)
  );

  assign op_b = alu_src ? imm : rs2_val;

  rv32_decode_alu_branch_alu u_alu (
    .alu_op (alu_op),
    .a      (rs1_val),
    .b      (op_b),
    .y      (alu_y)
  );

  rv32_decode_alu_branch_branch_unit u_branch_unit (
    .is_branch   (is_branch),
    .b_type      (b_type),
    .a           (rs1_val),
    .b           (rs2_val),
    .take_branch (take_branch)
  );

  always_comb begin
    if (jal_jump || jalr_jump) result = pc + 32'd4;
    else if (is_div)           result = '0;
    else if (is_lui)           result = imm;
    else if (is_auipc)         result = pc + imm;
    else                       result = alu_y;
  end

  assign pc_target = jalr_jump ? ((rs1_val + imm) & ~32'd1) : (pc + imm);

  // Fetch consumes the redirect one cycle after the branch/jump resolves.
  always_ff @(posedge clk) begin
    if (reset) flush <= 1'b0;
    else       flush <= jal_jump | jalr_jump | take_branch;
  end

endmodule

// File: tb/tb_rv32_decode_alu_branch.sv
// Directed and randomized bench for rv32_decode_alu_branch with an
// instruction-semantics reference model.
module tb_rv32_decode_alu_branch;

  logic        clk;
  logic        reset;
  logic [31:0] instr, pc, rs1_val, rs2_val;
  logic [4:0]  rd, rs1, rs2, alu_op;
  logic [31:0] imm, result, pc_target;
  logic        reg_write, alu_src, is_branch, jal_jump, jalr_jump, is_load, is_store;
  logic        is_lui, is_auipc, is_div, cpu_halt, illegal, take_branch, flush;
  logic [2:0]  b_type, load_type, store_type, div_op, csr_func;

  int checks = 0;
  int errors = 0;

  rv32_decode_alu_branch dut (
    .clk(clk), .reset(reset), .instr(instr), .pc(pc), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .alu_op(alu_op),
    .reg_write(reg_write), .alu_src(alu_src), .is_branch(is_branch), .jal_jump(jal_jump),
    .jalr_jump(jalr_jump), .is_load(is_load), .is_store(is_store), .is_lui(is_lui),
    .is_auipc(is_auipc), .is_div(is_div), .cpu_halt(cpu_halt), .illegal(illegal),
    .b_type(b_type), .load_type(load_type), .store_type(store_type), .div_op(div_op),
    .csr_func(csr_func), .result(result), .take_branch(take_branch), .pc_target(pc_target),
    .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  typedef struct packed {
    logic [4:0]  rd, rs1, rs2, op;
    logic [31:0] imm, result, target;
    logic        rw, src, br, jal, jalr, ld, st, lui, auipc, dv, halt, ill, take;
    logic [2:0]  bt, lt, stt, dop, csr;
  } exp_t;

  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    longint          p;
    longint unsigned pu;
    logic [4:0]      sh;
    sh = b[4:0];
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a << sh;
      3:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4:  return (a < b) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return a >> sh;
      7:  return 32'(int'(a) >>> sh);
      8:  return a | b;
      9:  return a & b;
      10: return a * b;
      11: begin p = longint'(int'(a)) * longint'(int'(b)); return p[63:32]; end
      12: begin p = longint'(int'(a)) * longint'({32'b0, b}); return p[63:32]; end
      13: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // Register-register / register-immediate operation numbers indexed by funct3.
  function automatic int base_num(input logic [2:0] f3);
    int tbl[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    return tbl[f3];
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] ii, si, bi, ui, ji;
    logic        cond;
    e   = '0;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    e.rd  = ins[11:7];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    ii = {{20{ins[31]}}, ins[31:20]};
    si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    bi = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ui = {ins[31:12], 12'b0};
    ji = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    case (opc)
      7'h33: begin
        e.rw = 1;
        if (f7 == 7'h01) begin
          if (f3 >= 3'd4) begin e.dv = 1; e.dop = f3; end
          else e.op = 5'(10 + int'(f3));
        end else if (f7 == 7'h00) e.op = 5'(base_num(f3));
        else if (f7 == 7'h20 && f3 == 3'd0) e.op = 5'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) e.op = 5'd7;
        else e.ill = 1;
      end
      7'h13: begin
        e.imm = ii; e.rw = 1; e.src = 1; e.op = 5'(base_num(f3));
        if (f3 == 3'd1 && f7 != 7'h00) e.ill = 1;
        if (f3 == 3'd5 && f7 == 7'h20) e.op = 5'd7;
        else if (f3 == 3'd5 && f7 != 7'h00) e.ill = 1;
      end
      7'h03: begin
        e.imm = ii;
        if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) begin
          e.ld = 1; e.lt = f3; e.rw = 1; e.src = 1;
        end else e.ill = 1;
      end
      7'h23: begin
        e.imm = si;
        if (f3 <= 3'd2) begin e.st = 1; e.stt = f3; e.src = 1; end
        else e.ill = 1;
      end
      7'h63: begin
        e.imm = bi;
        if (f3 == 3'd2 || f3 == 3'd3) e.ill = 1;
        else begin e.br = 1; e.bt = f3; end
      end
      7'h6F: begin e.imm = ji; e.jal = 1; e.rw = 1; end
      7'h67: begin e.imm = ii; e.jalr = 1; e.rw = 1; e.src = 1; end
      7'h37: begin e.imm = ui; e.lui = 1; e.rw = 1; e.src = 1; end
      7'h17: begin e.imm = ui; e.auipc = 1; e.rw = 1; e.src = 1; end
      7'h73: begin
        e.imm = ii;
        if (f3 == 3'd0) e.halt = 1;
        else begin e.csr = f3; e.rw = 1; end
      end
      7'h0F: e.imm = ii;
      default: e.ill = 1;
    endcase
    if (e.ill) begin
      e.op = 0; e.rw = 0; e.src = 0; e.br = 0; e.jal = 0; e.jalr = 0; e.ld = 0; e.st = 0;
      e.lui = 0; e.auipc = 0; e.dv = 0; e.halt = 0; e.bt = 0; e.lt = 0; e.stt = 0;
      e.dop = 0; e.csr = 0;
    end
    case (e.bt)
      3'd0: cond = (a == b);
      3'd1: cond = (a != b);
      3'd4: cond = (int'(a) <  int'(b));
      3'd5: cond = (int'(a) >= int'(b));
      3'd6: cond = (a <  b);
      default: cond = (a >= b);
    endcase
    e.take   = e.br && cond;
    e.target = e.jalr ? ((a + e.imm) & 32'hFFFF_FFFE) : (p + e.imm);
    if (e.jal || e.jalr) e.result = p + 32'd4;
    else if (e.dv)       e.result = 32'd0;
    else if (e.lui)      e.result = e.imm;
    else if (e.auipc)    e.result = p + e.imm;
    else                 e.result = alu_ref(int'(e.op), a, e.src ? e.imm : b);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s instr=%h observed=%h expected=%h", tag, instr, obs, exp);
    end
  endtask

  task automatic apply(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic r);
    exp_t e;
    @(negedge clk);
    instr = i; pc = p; rs1_val = a; rs2_val = b; reset = r;
    #1;
    e = model(i, p, a, b);
    check("rd", 32'(rd), 32'(e.rd));
    check("rs1", 32'(rs1), 32'(e.rs1));
    check("rs2", 32'(rs2), 32'(e.rs2));
    check("imm", imm, e.imm);
    check("alu_op", 32'(alu_op), 32'(e.op));
    check("flags",
          32'({reg_write, alu_src, is_branch, jal_jump, jalr_jump, is_load, is_store,
               is_lui, is_auipc, is_div, cpu_halt, illegal}),
          32'({e.rw, e.src, e.br, e.jal, e.jalr, e.ld, e.st, e.lui, e.auipc, e.dv, e.halt, e.ill}));
    check("funct3_fields", 32'({b_type, load_type, store_type, div_op, csr_func}),
          32'({e.bt, e.lt, e.stt, e.dop, e.csr}));
    check("result", result, e.result);
    check("take_branch", 32'(take_branch), 32'(e.take));
    check("pc_target", pc_target, e.target);
    @(posedge clk);
    #1;
    check("flush", 32'(flush), r ? 32'd0 : 32'(e.jal | e.jalr | e.take));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  opc, f7;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: opc = 7'h33;  1: opc = 7'h13;  2: opc = 7'h03;  3: opc = 7'h23;
      4: opc = 7'h63;  5: opc = 7'h6F;  6: opc = 7'h67;  7: opc = 7'h37;
      8: opc = 7'h17;  9: opc = 7'h73; 10: opc = 7'h0F;
      default: return w;
    endcase
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = w[31:25];
    endcase
    return {f7, w[24:7], opc};
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] beq_i, mulh_i, mulhu_i, mulhsu_i, div_i, ri, ra, rb, rp;

  initial begin
    reset = 1'b1; instr = '0; pc = '0; rs1_val = '0; rs2_val = '0;
    beq_i    = 32'h0020_8463;
    mulh_i   = {7'h01, 5'd3, 5'd2, 3'b001, 5'd1, 7'h33};
    mulhsu_i = {7'h01, 5'd3, 5'd2, 3'b010, 5'd1, 7'h33};
    mulhu_i  = {7'h01, 5'd3, 5'd2, 3'b011, 5'd1, 7'h33};
    div_i    = {7'h01, 5'd3, 5'd2, 3'b100, 5'd1, 7'h33};

    // Reset held over a taken branch, then released.
    apply(beq_i, 32'h100, 32'd4, 32'd4, 1'b1);
    check("rst_hold_flush", 32'(flush), 32'd0);
    check("beq_take", 32'(take_branch), 32'd1);
    check("beq_target", pc_target, 32'h108);
    apply(beq_i, 32'h100, 32'd4, 32'd4, 1'b0);
    check("rst_release_flush", 32'(flush), 32'd1);
    apply(beq_i, 32'h100, 32'd4, 32'd5, 1'b0);
    check("beq_nt_take", 32'(take_branch), 32'd0);
    check("beq_nt_flush", 32'(flush), 32'd0);

    apply(32'h0020_81B3, 32'h0, 32'd5, 32'd7, 1'b0);
    check("add_rd", 32'(rd), 32'd3);
    check("add_reg_write", 32'(reg_write), 32'd1);
    check("add_alu_op", 32'(alu_op), 32'd0);
    check("add_result", result, 32'd12);
    check("add_illegal", 32'(illegal), 32'd0);

    apply(32'h4043_5293, 32'h0, 32'h8000_0000, 32'h0, 1'b0);
    check("srai_alu_op", 32'(alu_op), 32'd7);
    check("srai_shamt", 32'(imm[4:0]), 32'd4);
    check("srai_result", result, 32'hF800_0000);

    apply(32'h0031_00E7, 32'h40, 32'h200, 32'h0, 1'b0);
    check("jalr_target", pc_target, 32'h202);
    check("jalr_result", result, 32'h44);
    check("jalr_flush", 32'(flush), 32'd1);

    apply(32'h1234_50B7, 32'h0, 32'h0, 32'h0, 1'b0);
    check("lui_result", result, 32'h1234_5000);

    apply(32'hFFFF_FFFF, 32'h0, 32'h1, 32'h2, 1'b0);
    check("illegal_flag", 32'(illegal), 32'd1);
    check("illegal_reg_write", 32'(reg_write), 32'd0);

    apply(mulh_i, 32'h0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    check("mulh_result", result, 32'h4000_0000);
    apply(mulhsu_i, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("mulhsu_result", result, 32'hFFFF_FFFF);
    apply(mulhu_i, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("mulhu_result", result, 32'hFFFF_FFFE);
    apply(div_i, 32'h0, 32'd100, 32'd7, 1'b0);
    check("div_result", result, 32'd0);
    check("div_flag", 32'(is_div), 32'd1);
    apply(32'h0000_0073, 32'h0, 32'd1, 32'd2, 1'b0);
    check("ecall_halt", 32'(cpu_halt), 32'd1);
    check("ecall_reg_write", 32'(reg_write), 32'd0);

    for (int n = 0; n < 600; n++) begin
      ri = rand_instr();
      ra = rand_val();
      rb = ($urandom_range(0, 3) == 0) ? ra : rand_val();
      rp = $urandom;
      rp[1:0] = 2'b00;
      apply(ri, rp, ra, rb, ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
